// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory sequencer: req/ack bus handshake, byte strobes, load alignment and extension.
// Optional MISALIGN_TRAP_EN: misaligned H/HU/W accesses trap instead of being force-aligned.
module mem_access_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  DataSize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        access_fault,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       size_q;
    logic [1:0]       off_q;
    logic             is_load_q;

    logic        access;
    logic        size_ok;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [31:0] wrep;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] ld_ext;

    assign access = MemRead | MemWrite;

    // Stores only accept B/H/W; the unsigned variants are load-only.
    always_comb begin
        size_ok = 1'b0;
        case (DataSize)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = ~MemWrite;
            default:                size_ok = 1'b0;
        endcase

        off  = addr[1:0];
        strb = 4'b1111;
        wrep = wdata;
        case (DataSize[1:0])
            2'b00: begin
                strb = 4'b0001 << addr[1:0];
                wrep = {4{wdata[7:0]}};
            end
            2'b01: begin
                off  = {addr[1], 1'b0};
                strb = 4'b0011 << {addr[1], 1'b0};
                wrep = {2{wdata[15:0]}};
            end
            default: off = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_hit;
    logic err_mis;
    assign mis_hit = ((DataSize[1:0] == 2'b01) && addr[0]) ||
                     ((DataSize[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign access_fault = (state == S_ERR) && !err_mis;
    assign misalign     = (state == S_ERR) && err_mis;
`else
    assign access_fault = (state == S_ERR);
    assign misalign     = 1'b0;
`endif

    // Reset gates stall so an aborted access releases the pipeline immediately.
    assign stall = ~rst & (((state == S_IDLE) & access) | (state == S_REQ));

    always_comb begin
        case (off_q)
            2'd0:    sel_b = bus_rdata[7:0];
            2'd1:    sel_b = bus_rdata[15:8];
            2'd2:    sel_b = bus_rdata[23:16];
            default: sel_b = bus_rdata[31:24];
        endcase
        sel_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            3'b000:  ld_ext = {{24{sel_b[7]}}, sel_b};
            3'b001:  ld_ext = {{16{sel_h[15]}}, sel_h};
            3'b100:  ld_ext = {24'd0, sel_b};
            3'b101:  ld_ext = {16'd0, sel_h};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            size_q    <= 3'd0;
            off_q     <= 2'd0;
            is_load_q <= 1'b0;
            ld_data   <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wstrb <= 4'd0;
            bus_wdata <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            err_mis   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        size_q    <= DataSize;
                        off_q     <= off;
                        is_load_q <= ~MemWrite;
                        cnt       <= '0;
`ifdef MISALIGN_TRAP_EN
                        err_mis   <= size_ok & mis_hit;
                        if (!size_ok || mis_hit) begin
`else
                        if (!size_ok) begin
`endif
                            state <= S_ERR;
                        end else begin
                            state     <= S_REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= MemWrite;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wstrb <= MemWrite ? strb : 4'b0000;
                            bus_wdata <= wrep;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= S_DONE;
                        if (is_load_q) begin
                            ld_data <= ld_ext;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus_req <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: per-cycle compare against a transaction-level model
// plus hand-computed literal expectations.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 256;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  DataSize = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;
    logic [31:0] ld_data;
    logic        stall;
    logic        access_fault;
    logic        misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .DataSize(DataSize), .addr(addr), .wdata(wdata), .ld_data(ld_data),
        .stall(stall), .access_fault(access_fault), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          chk_en = 1'b0;
    bit          exp_stall, exp_req, exp_fault, exp_mis, exp_we;
    logic [31:0] exp_ld = 32'd0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;

    int          stall_cycles, fault_pulses, mis_pulses, req_cycles;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: access width in bytes, natural lane, strobes, replicated data, extended load result.
    function automatic int nbytes(input logic [2:0] s);
        return 1 << s[1:0];
    endfunction

    function automatic bit legal(input bit wr, input logic [2:0] s);
        if (wr) return (s == 3'd0) || (s == 3'd1) || (s == 3'd2);
        return (s == 3'd0) || (s == 3'd1) || (s == 3'd2) || (s == 3'd4) || (s == 3'd5);
    endfunction

    function automatic int lane(input logic [2:0] s, input logic [31:0] a);
        int lo = int'(a[1:0]);
        return (lo / nbytes(s)) * nbytes(s);
    endfunction

    function automatic logic [3:0] m_strobe(input logic [2:0] s, input logic [31:0] a);
        int st = ((1 << nbytes(s)) - 1) << lane(s, a);
        return st[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(s)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
        int          n = nbytes(s);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
        logic [31:0] v = (rd >> (8*lane(s, a))) & mask;
        if (!s[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("stall", 32'(stall), 32'(exp_stall));
            checkOutput("bus_req", 32'(bus_req), 32'(exp_req));
            checkOutput("access_fault", 32'(access_fault), 32'(exp_fault));
            checkOutput("misalign", 32'(misalign), 32'(exp_mis));
            checkOutput("ld_data", ld_data, exp_ld);
            if (exp_req) begin
                checkOutput("bus_addr", bus_addr, exp_addr);
                checkOutput("bus_we", 32'(bus_we), 32'(exp_we));
                checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
                if (exp_we) checkOutput("bus_wdata", bus_wdata, exp_wdata);
            end
        end
    end

    always @(negedge clk) begin
        if (stall) stall_cycles++;
        if (access_fault) fault_pulses++;
        if (misalign) mis_pulses++;
        if (bus_req) begin
            req_cycles++;
            seen_addr  = bus_addr;
            seen_wstrb = bus_wstrb;
            seen_wdata = bus_wdata;
        end
    end

    task automatic clearMon();
        stall_cycles = 0;
        fault_pulses = 0;
        mis_pulses   = 0;
        req_cycles   = 0;
        seen_addr    = 32'd0;
        seen_wstrb   = 4'd0;
        seen_wdata   = 32'd0;
    endtask

    // One instruction from IDLE; ack_at = REQ cycle index carrying bus_ack, -1 for never.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] s, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdat, input int ack_at);
        bit go_err = !legal(wr, s);
        bit mis = 1'b0;
        bit acked = 1'b0;
        if (!go_err && TRAP && (int'(a[1:0]) % nbytes(s)) != 0) begin
            go_err = 1'b1;
            mis    = 1'b1;
        end
        clearMon();
        MemRead = rd; MemWrite = wr; DataSize = s; addr = a; wdata = wd;
        exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0; exp_mis = 1'b0;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; DataSize = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (go_err) begin
            exp_stall = 1'b0; exp_fault = !mis; exp_mis = mis;
            @(posedge clk); #1;
        end else begin
            exp_addr  = a & 32'hFFFF_FFFC;
            exp_we    = wr;
            exp_wstrb = wr ? m_strobe(s, a) : 4'd0;
            exp_wdata = m_wdata(s, wd);
            exp_req   = 1'b1;
            for (int k = 0; k < TIMEOUT; k++) begin
                if (k == ack_at) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdat;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0;
                bus_rdata = $urandom;
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            exp_req = 1'b0; exp_stall = 1'b0;
            if (acked) begin
                if (!wr) exp_ld = m_load(s, a, rdat);
                MemRead = 1'b1; DataSize = 3'b010;
                @(posedge clk); #1;
                MemRead = 1'b0;
            end else begin
                exp_fault = 1'b1;
                @(posedge clk); #1;
            end
        end
        exp_fault = 1'b0; exp_mis = 1'b0; exp_stall = 1'b0; exp_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        clearMon();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_ld_data", ld_data, 32'd0);
        checkOutput("rst_fault", 32'(access_fault), 32'd0);
        checkOutput("rst_wstrb", 32'(bus_wstrb), 32'd0);
        rst = 1'b0;
        exp_ld = 32'd0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checkOutput("lw_stall_cycles", stall_cycles, 2);
        checkOutput("lw_bus_addr", seen_addr, 32'h100);
        checkOutput("lw_ld_data", ld_data, 32'hDEADBEEF);

        applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 1);
        checkOutput("lb_ld_data", ld_data, 32'hFFFFFF80);
        applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0);
        checkOutput("lbu_ld_data", ld_data, 32'h00000080);
        applyStimulus(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF7F01, 2);
        checkOutput("lhu_ld_data", ld_data, 32'h000080FF);
        applyStimulus(1, 0, 3'b001, 32'h100, 32'h0, 32'h1234F00D, 3);
        checkOutput("lh_ld_data", ld_data, 32'hFFFFF00D);

        applyStimulus(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0);
        checkOutput("sb_wstrb", 32'(seen_wstrb), 32'b0010);
        checkOutput("sb_wdata", seen_wdata, 32'hABABABAB);
        checkOutput("sb_ld_hold", ld_data, 32'hFFFFF00D);
        applyStimulus(0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 2);
        checkOutput("sh_wstrb", 32'(seen_wstrb), 32'b1100);
        applyStimulus(1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h11111111, 1);
        checkOutput("rdwr_as_write_ld_hold", ld_data, 32'hFFFFF00D);

        applyStimulus(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        checkOutput("illegal_ld_fault", fault_pulses, 1);
        checkOutput("illegal_ld_noreq", req_cycles, 0);
        applyStimulus(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        checkOutput("illegal_st_fault", fault_pulses, 1);

        applyStimulus(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, -1);
        checkOutput("timeout_fault", fault_pulses, 1);
        checkOutput("timeout_req_cycles", req_cycles, TIMEOUT);
        applyStimulus(1, 0, 3'b010, 32'h500, 32'h0, 32'h13572468, 0);
        checkOutput("after_timeout_ld", ld_data, 32'h13572468);

        applyStimulus(0, 1, 3'b010, 32'h301, 32'h87654321, 32'h0, 0);
        if (TRAP) begin
            checkOutput("sw_mis_pulse", mis_pulses, 1);
            checkOutput("sw_mis_noreq", req_cycles, 0);
        end else begin
            checkOutput("sw_forced_addr", seen_addr, 32'h300);
            checkOutput("sw_forced_wstrb", 32'(seen_wstrb), 32'b1111);
        end
        applyStimulus(1, 0, 3'b001, 32'h103, 32'h0, 32'h9ABC1234, 0);

        chk_en = 1'b0;
        clearMon();
        MemRead = 1'b1; DataSize = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        MemRead = 1'b0;
        checkOutput("pre_rst_in_req", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_mid_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mid_no_fault", fault_pulses + mis_pulses, 0);
        exp_ld = 32'd0;
        chk_en = 1'b1;
        applyStimulus(1, 0, 3'b000, 32'h700, 32'h0, 32'h0000007F, 0);
        checkOutput("post_rst_lb", ld_data, 32'h0000007F);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
